instruction_fetch: RTL and testbench

Fetch stage of the BaLuGa 9-bit core. Owns the program counter, drives the 8-bit address of the combinational instruction ROM, and registers the returned 9-bit word into an instruction register (IR) for the decode/execute stage. It handles redirects (taken branches and jumps) from execute, back-pressure, and detection of the `halt` encoding. It also provides start/restart control and a fetch counter for program-level tests.

---
 rtl/baluga_pkg.sv | 29 ++
 rtl/instruction_fetch_if.sv | 31 +++
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baluga_pkg.sv
//----------------------------------------------------------------------
// baluga_pkg: shared widths, opcodes and fetch state type for BaLuGa
// rev 1.0
//----------------------------------------------------------------------
`default_nettype none

package baluga_pkg;

   localparam int INSN_W = 9;
   localparam int ADDR_W = 8;

   localparam int OPC_MSB = 8;
   localparam int OPC_LSB = 5;

   localparam logic [3:0] OP_BEQ = 4'b1100;
   localparam logic [3:0] OP_BL  = 4'b1101;
   localparam logic [3:0] OP_JMP = 4'b1110;

   localparam logic [INSN_W-1:0] HALT_INSN = 9'b0111_00_010;

   typedef enum logic [1:0] {
      FS_IDLE   = 2'd0,
      FS_RUN    = 2'd1,
      FS_HALTED = 2'd2
   } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_if.sv
//----------------------------------------------------------------------
// instruction_fetch_if: ROM port plus IR/redirect link to execute
// rev 1.0
//----------------------------------------------------------------------
`default_nettype none

interface instruction_fetch_if;
   import baluga_pkg::*;

   logic [ADDR_W-1:0] rom_addr;
   logic [INSN_W-1:0] rom_data;
   logic              stall;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_target;
   logic [INSN_W-1:0] ir;
   logic [ADDR_W-1:0] ir_pc;
   logic              ir_valid;

   modport master (
      output rom_addr, ir, ir_pc, ir_valid,
      input  rom_data, stall, redirect_valid, redirect_target
   );

   modport slave (
      input  rom_addr, ir, ir_pc, ir_valid,
      output rom_data, stall, redirect_valid, redirect_target
   );

endinterface

`default_nettype wire

// File: rtl/instruction_fetch.sv
//----------------------------------------------------------------------
// instruction_fetch: BaLuGa program counter, ROM addressing and IR stage
// rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module instruction_fetch #(
   parameter logic [baluga_pkg::ADDR_W-1:0] RESET_PC  = 8'd0,
   parameter logic [baluga_pkg::INSN_W-1:0] HALT_INSN = baluga_pkg::HALT_INSN
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   instruction_fetch_if.master bus,
   output logic                running,
   output logic                halted,
   output logic [15:0]         fetch_count
);
   import baluga_pkg::*;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INSN_W-1:0] ir_q, ir_d;
   logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
   logic              ir_valid_q, ir_valid_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              running_q, halted_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FS_IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= '0;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
         cnt_q      <= '0;
         running_q  <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
         cnt_q      <= cnt_d;
         running_q  <= (state_d == FS_RUN);
         halted_q   <= (state_d == FS_HALTED);
      end
   end

   // rom_data is only looked at in the RUN fetch branch, so X from an idle ROM never lands in IR
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      cnt_d      = cnt_q;
      case (state_q)
         FS_IDLE: begin
            pc_d       = RESET_PC;
            ir_valid_d = 1'b0;
            cnt_d      = '0;
            if (start) state_d = FS_RUN;
         end
         FS_RUN: begin
            if (bus.redirect_valid) begin
               pc_d       = bus.redirect_target;
               ir_valid_d = 1'b0;
            end else if (!bus.stall) begin
               ir_d       = bus.rom_data;
               ir_pc_d    = pc_q;
               ir_valid_d = 1'b1;
               cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
               if (bus.rom_data == HALT_INSN) state_d = FS_HALTED;
               else                           pc_d    = pc_q + 8'd1;
            end
         end
         FS_HALTED: begin
            if (start) begin
               state_d    = FS_RUN;
               pc_d       = RESET_PC;
               ir_valid_d = 1'b0;
               cnt_d      = '0;
            end else if (!bus.stall) begin
               ir_valid_d = 1'b0;
            end
         end
         default: begin
            state_d    = FS_IDLE;
            pc_d       = RESET_PC;
            ir_valid_d = 1'b0;
         end
      endcase
   end

   assign bus.rom_addr = pc_q;
   assign bus.ir       = ir_q;
   assign bus.ir_pc    = ir_pc_q;
   assign bus.ir_valid = ir_valid_q;
   assign running      = running_q;
   assign halted       = halted_q;
   assign fetch_count  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
//----------------------------------------------------------------------
// tb_instruction_fetch: directed scenarios plus random run against a model
// rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch;

   localparam logic [8:0] HALT = 9'b0111_00_010;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        running, halted;
   logic [15:0] fetch_count;
   logic [8:0]  rom [0:255];
   int          n_tests = 0;
   int          n_fail  = 0;

   instruction_fetch_if bus();

   assign bus.rom_data = rom[bus.rom_addr];

   instruction_fetch #(.RESET_PC(8'd0), .HALT_INSN(HALT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .bus         (bus),
      .running     (running),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fill_rom;
      logic [8:0] w;
      for (int i = 0; i < 256; i++) begin
         w = 9'($urandom);
         if (w == HALT) w = w ^ 9'h001;
         rom[i] = w;
      end
   endtask

   task automatic do_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0;
      bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 8'd0;
      fill_rom();
      repeat (3) tick();
      n_tests++;
      if (bus.rom_addr !== 8'd0 || bus.ir !== 9'd0 || bus.ir_pc !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_regs: rom_addr=%h ir=%h ir_pc=%h, want 00 000 00", bus.rom_addr, bus.ir, bus.ir_pc);
      end
      n_tests++;
      if (bus.ir_valid !== 1'b0 || running !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_flags: v=%b run=%b halt=%b cnt=%0d, want 0 0 0 0", bus.ir_valid, running, halted, fetch_count);
      end
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (running !== 1'b0 || bus.ir_valid !== 1'b0 || bus.rom_addr !== 8'd0) begin
         n_fail++;
         $display("FAIL idle_hold: run=%b v=%b rom_addr=%h, want 0 0 00", running, bus.ir_valid, bus.rom_addr);
      end
   endtask

   task automatic test_stream;
      do_start();
      n_tests++;
      if (running !== 1'b1 || bus.ir_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL start_edge: run=%b v=%b, want 1 0", running, bus.ir_valid);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_tests++;
         if (bus.ir !== rom[k] || bus.ir_pc !== 8'(k) || bus.ir_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_%0d: ir=%h pc=%h v=%b, want %h %h 1", k, bus.ir, bus.ir_pc, bus.ir_valid, rom[k], 8'(k));
         end
      end
      n_tests++;
      if (fetch_count !== 16'd4) begin
         n_fail++;
         $display("FAIL stream_count: got %0d want 4", fetch_count);
      end
   endtask

   task automatic test_redirect;
      repeat (10) tick();
      bus.redirect_valid = 1'b1; bus.redirect_target = 8'd6;
      tick();
      bus.redirect_valid = 1'b0;
      n_tests++;
      if (bus.ir_valid !== 1'b0 || bus.rom_addr !== 8'd6) begin
         n_fail++;
         $display("FAIL redirect_bubble: v=%b rom_addr=%h, want 0 06", bus.ir_valid, bus.rom_addr);
      end
      tick();
      n_tests++;
      if (bus.ir_pc !== 8'd6 || bus.ir !== rom[6] || bus.ir_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL redirect_target: pc=%h ir=%h v=%b, want 06 %h 1", bus.ir_pc, bus.ir, bus.ir_valid, rom[6]);
      end
      tick();
      n_tests++;
      if (bus.ir_pc !== 8'd7 || fetch_count !== 16'd16) begin
         n_fail++;
         $display("FAIL redirect_next: pc=%h cnt=%0d, want 07 16", bus.ir_pc, fetch_count);
      end
   endtask

   task automatic test_stall;
      repeat (2) tick();
      bus.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_tests++;
         if (bus.ir !== rom[9] || bus.ir_pc !== 8'd9 || bus.rom_addr !== 8'd10 || fetch_count !== 16'd18 || bus.ir_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold_%0d: ir=%h pc=%h addr=%h cnt=%0d v=%b, want %h 09 0a 18 1", k, bus.ir, bus.ir_pc, bus.rom_addr, fetch_count, bus.ir_valid, rom[9]);
         end
      end
      bus.stall = 1'b0;
      tick();
      n_tests++;
      if (bus.ir_pc !== 8'd10 || bus.ir !== rom[10] || fetch_count !== 16'd19) begin
         n_fail++;
         $display("FAIL stall_resume: pc=%h ir=%h cnt=%0d, want 0a %h 19", bus.ir_pc, bus.ir, fetch_count, rom[10]);
      end
   endtask

   task automatic test_halt;
      rom[17] = HALT;
      repeat (7) tick();
      n_tests++;
      if (bus.ir !== HALT || bus.ir_pc !== 8'd17 || bus.ir_valid !== 1'b1 || halted !== 1'b1 || running !== 1'b0 || bus.rom_addr !== 8'd17) begin
         n_fail++;
         $display("FAIL halt_deliver: ir=%h pc=%h v=%b halt=%b run=%b addr=%h, want %h 11 1 1 0 11", bus.ir, bus.ir_pc, bus.ir_valid, halted, running, bus.rom_addr, HALT);
      end
      rom[17] = 9'h0A5; rom[18] = 9'h03C;
      bus.redirect_valid = 1'b1; bus.redirect_target = 8'd40;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_tests++;
         if (bus.ir_valid !== 1'b0 || halted !== 1'b1 || bus.rom_addr !== 8'd17 || bus.ir !== HALT) begin
            n_fail++;
            $display("FAIL halt_frozen_%0d: v=%b halt=%b addr=%h ir=%h, want 0 1 11 %h", k, bus.ir_valid, halted, bus.rom_addr, bus.ir, HALT);
         end
      end
      bus.redirect_valid = 1'b0;
   endtask

   task automatic test_squash_restart;
      logic [8:0] saved;
      saved = rom[3];
      rom[3] = HALT;
      do_start();
      n_tests++;
      if (running !== 1'b1 || halted !== 1'b0 || fetch_count !== 16'd0 || bus.ir_valid !== 1'b0 || bus.rom_addr !== 8'd0) begin
         n_fail++;
         $display("FAIL restart: run=%b halt=%b cnt=%0d v=%b addr=%h, want 1 0 0 0 00", running, halted, fetch_count, bus.ir_valid, bus.rom_addr);
      end
      tick();
      n_tests++;
      if (bus.ir_pc !== 8'd0 || bus.ir !== rom[0] || fetch_count !== 16'd1) begin
         n_fail++;
         $display("FAIL restart_first: pc=%h ir=%h cnt=%0d, want 00 %h 1", bus.ir_pc, bus.ir, fetch_count, rom[0]);
      end
      repeat (2) tick();
      bus.redirect_valid = 1'b1; bus.redirect_target = 8'd50;
      tick();
      bus.redirect_valid = 1'b0;
      n_tests++;
      if (running !== 1'b1 || halted !== 1'b0 || bus.rom_addr !== 8'd50 || bus.ir_valid !== 1'b0 || fetch_count !== 16'd3) begin
         n_fail++;
         $display("FAIL squash_halt: run=%b halt=%b addr=%h v=%b cnt=%0d, want 1 0 32 0 3", running, halted, bus.rom_addr, bus.ir_valid, fetch_count);
      end
      tick();
      n_tests++;
      if (bus.ir_pc !== 8'd50 || bus.ir_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL squash_next: pc=%h v=%b, want 32 1", bus.ir_pc, bus.ir_valid);
      end
      rom[3] = saved;
   endtask

   task automatic test_wrap;
      bus.redirect_valid = 1'b1; bus.redirect_target = 8'hFF;
      tick();
      bus.redirect_valid = 1'b0;
      tick();
      n_tests++;
      if (bus.ir_pc !== 8'hFF || bus.rom_addr !== 8'h00) begin
         n_fail++;
         $display("FAIL wrap_ff: pc=%h addr=%h, want ff 00", bus.ir_pc, bus.rom_addr);
      end
      tick();
      n_tests++;
      if (bus.ir_pc !== 8'h00 || bus.ir !== rom[0] || bus.rom_addr !== 8'h01) begin
         n_fail++;
         $display("FAIL wrap_00: pc=%h ir=%h addr=%h, want 00 %h 01", bus.ir_pc, bus.ir, bus.rom_addr, rom[0]);
      end
   endtask

   task automatic test_async_reset;
      tick();
      rst_n = 1'b0;
      #2;
      n_tests++;
      if (bus.rom_addr !== 8'd0 || bus.ir !== 9'd0 || bus.ir_pc !== 8'd0 || bus.ir_valid !== 1'b0 ||
          running !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'd0) begin
         n_fail++;
         $display("FAIL async_reset: addr=%h ir=%h pc=%h v=%b run=%b halt=%b cnt=%0d, want all zero",
                  bus.rom_addr, bus.ir, bus.ir_pc, bus.ir_valid, running, halted, fetch_count);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Reference: 0 idle, 1 run, 2 halted; advanced once per clock from the sampled inputs
   task automatic test_random;
      int         m_mode;
      logic [7:0] m_pc, m_irpc;
      logic [8:0] m_ir, w;
      logic       m_v;
      int         m_cnt;
      logic [43:0] got, exp;
      rst_n = 1'b0;
      for (int i = 0; i < 256; i++) begin
         w = 9'($urandom);
         if (w == HALT) w = w ^ 9'h001;
         rom[i] = ($urandom_range(0, 24) == 0) ? HALT : w;
      end
      tick();
      rst_n = 1'b1;
      m_mode = 0; m_pc = 8'd0; m_irpc = 8'd0; m_ir = 9'd0; m_v = 1'b0; m_cnt = 0;
      for (int c = 0; c < 600; c++) begin
         start               = ($urandom_range(0, 19) == 0);
         bus.stall           = ($urandom_range(0, 3) == 0);
         bus.redirect_valid  = ($urandom_range(0, 7) == 0);
         bus.redirect_target = 8'($urandom);
         if (m_mode == 0) begin
            if (start) begin m_mode = 1; m_cnt = 0; end
         end else if (m_mode == 1) begin
            if (bus.redirect_valid) begin
               m_pc = bus.redirect_target; m_v = 1'b0;
            end else if (!bus.stall) begin
               m_ir = rom[m_pc]; m_irpc = m_pc; m_v = 1'b1;
               if (m_cnt < 65535) m_cnt = m_cnt + 1;
               if (m_ir == HALT) m_mode = 2;
               else              m_pc = 8'((int'(m_pc) + 1) % 256);
            end
         end else begin
            if (start) begin m_mode = 1; m_pc = 8'd0; m_v = 1'b0; m_cnt = 0; end
            else if (!bus.stall) m_v = 1'b0;
         end
         tick();
         got = {bus.rom_addr, bus.ir, bus.ir_pc, bus.ir_valid, running, halted, fetch_count};
         exp = {m_pc, m_ir, m_irpc, m_v, (m_mode == 1), (m_mode == 2), 16'(m_cnt)};
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL random_cyc%0d: got addr=%h ir=%h pc=%h v=%b run=%b halt=%b cnt=%0d, want addr=%h ir=%h pc=%h v=%b run=%b halt=%b cnt=%0d",
                     c, got[43:36], got[35:27], got[26:19], got[18], got[17], got[16], got[15:0],
                     exp[43:36], exp[35:27], exp[26:19], exp[18], exp[17], exp[16], exp[15:0]);
         end
      end
      start = 1'b0; bus.stall = 1'b0; bus.redirect_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_redirect();
      test_stall();
      test_halt();
      test_squash_restart();
      test_wrap();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
